// File: rtl/vend_pkg.sv
// Shared slot indices, state encoding and small helpers for the dispense scheduler.
package vend_pkg;
    localparam int NUM_SLOTS  = 3;
    localparam int SLOT_COKE  = 0;
    localparam int SLOT_PEPSI = 1;
    localparam int SLOT_SOFT  = 2;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        WAIT_DROP,
        FAULT
    } vend_state_e;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_SLOTS-1:0] oh);
        if (oh[SLOT_PEPSI]) return 2'(SLOT_PEPSI);
        if (oh[SLOT_SOFT])  return 2'(SLOT_SOFT);
        return 2'(SLOT_COKE);
    endfunction
endpackage

// File: rtl/vend_dispense_scheduler_if.sv
// Selection/motor/restock signal bundle between drink_machine and the dispense scheduler.
interface vend_dispense_scheduler_if #(
    parameter int INV_W = 4
);
    import vend_pkg::*;

    logic [NUM_SLOTS-1:0] vend_req;
    logic                 drop_sense;
    logic                 restock;
    logic [1:0]           restock_slot;
    logic [INV_W-1:0]     restock_qty;
    logic                 fault_clear;
    logic [NUM_SLOTS-1:0] motor_en;
    logic                 busy;
    logic [NUM_SLOTS-1:0] dispensed;
    logic [NUM_SLOTS-1:0] refund;
    logic [NUM_SLOTS-1:0] sold_out;
    logic                 fault;

    modport master (
        output vend_req, drop_sense, restock, restock_slot, restock_qty, fault_clear,
        input  motor_en, busy, dispensed, refund, sold_out, fault
    );

    modport slave (
        input  vend_req, drop_sense, restock, restock_slot, restock_qty, fault_clear,
        output motor_en, busy, dispensed, refund, sold_out, fault
    );
endinterface

// File: rtl/vend_rr_arbiter.sv
// Combinational round-robin pick over the three slots, searching from ptr+1 (mod 3).
module vend_rr_arbiter
    import vend_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] req,
    input  logic [1:0]           ptr,
    output logic [NUM_SLOTS-1:0] gnt,
    output logic                 valid
);
    always_comb begin
        gnt = '0;
        case (ptr)
            2'd0: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            2'd1: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

    assign valid = |req;
endmodule

// File: rtl/vend_dispense_scheduler.sv
// Shared dispensing motor sequencer: request intake, round-robin grant, timed drive,
// drop-sensor wait with jam timeout, and per-slot inventory.
module vend_dispense_scheduler
    import vend_pkg::*;
#(
    parameter int INV_W        = 4,
    parameter int INIT_STOCK   = 8,
    parameter int MAX_STOCK    = 15,
    parameter int DRIVE_CYCLES = 4,
    parameter int DROP_TIMEOUT = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    vend_dispense_scheduler_if.slave  bus
);
    localparam int CNT_MAX = (DRIVE_CYCLES > DROP_TIMEOUT) ? DRIVE_CYCLES : DROP_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST   = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DROP_TIMEOUT - 1);

    vend_state_e          state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [NUM_SLOTS-1:0] grant, grant_n;
    logic [1:0]           ptr, ptr_n;
    logic [NUM_SLOTS-1:0] pending, pending_n;
    logic [NUM_SLOTS-1:0] motor_en, motor_en_n;
    logic [NUM_SLOTS-1:0] dispensed, dispensed_n;
    logic [NUM_SLOTS-1:0] refund, refund_n;
    logic                 fault, fault_n;
    logic [NUM_SLOTS-1:0] dec;
    logic [NUM_SLOTS-1:0] granted, reject, accept;
    logic [NUM_SLOTS-1:0] sold_out;
    logic [NUM_SLOTS-1:0] arb_gnt;
    logic                 arb_valid;
    logic [INV_W-1:0]     inv [NUM_SLOTS];

    // old - dec + qty, clamped at MAX_STOCK; dec never hits an empty slot
    function automatic logic [INV_W-1:0] next_stock(input logic [INV_W-1:0] old,
                                                    input logic dec_i,
                                                    input logic [INV_W-1:0] qty);
        logic [INV_W:0] sum;
        sum = {1'b0, old} + {1'b0, qty} - {{INV_W{1'b0}}, dec_i};
        if (sum > (INV_W+1)'(MAX_STOCK)) return INV_W'(MAX_STOCK);
        return sum[INV_W-1:0];
    endfunction

    vend_rr_arbiter u_arb (
        .req   (pending),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) sold_out[i] = (inv[i] == '0);
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        grant_n     = grant;
        ptr_n       = ptr;
        motor_en_n  = '0;
        dispensed_n = '0;
        fault_n     = fault;
        dec         = '0;
        granted     = (state == DRIVE || state == WAIT_DROP) ? grant : '0;
        reject      = bus.vend_req & (sold_out | pending | granted);
        accept      = bus.vend_req & ~reject;
        refund_n    = reject;
        pending_n   = pending | accept;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    grant_n    = arb_gnt;
                    pending_n  = pending_n & ~arb_gnt;
                    ptr_n      = onehot_to_idx(arb_gnt);
                    motor_en_n = arb_gnt;
                    cnt_n      = '0;
                    state_n    = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    cnt_n   = '0;
                    state_n = WAIT_DROP;
                end else begin
                    motor_en_n = grant;
                    cnt_n      = cnt + 1'b1;
                end
            end
            WAIT_DROP: begin
                if (bus.drop_sense) begin
                    dispensed_n = grant;
                    dec         = grant;
                    state_n     = IDLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    refund_n = refund_n | grant;
                    fault_n  = 1'b1;
                    state_n  = FAULT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            FAULT: begin
                if (bus.fault_clear) begin
                    fault_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            grant     <= '0;
            ptr       <= 2'(SLOT_SOFT);
            pending   <= '0;
            motor_en  <= '0;
            dispensed <= '0;
            refund    <= '0;
            fault     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            grant     <= grant_n;
            ptr       <= ptr_n;
            pending   <= pending_n;
            motor_en  <= motor_en_n;
            dispensed <= dispensed_n;
            refund    <= refund_n;
            fault     <= fault_n;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (reset) inv[i] <= INV_W'(INIT_STOCK);
            else inv[i] <= next_stock(inv[i], dec[i],
                                      (bus.restock && bus.restock_slot == 2'(i)) ? bus.restock_qty : '0);
        end
    end

    assign bus.motor_en  = motor_en;
    assign bus.busy      = (state != IDLE);
    assign bus.dispensed = dispensed;
    assign bus.refund    = refund;
    assign bus.sold_out  = sold_out;
    assign bus.fault     = fault;
endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// Randomized and directed bench for vend_dispense_scheduler against a cycle-timeline
// reference model (grant edge plus relative offsets for drive and drop window).
module tb_vend_dispense_scheduler;
    localparam int INV_W = 4;
    localparam int INIT  = 8;
    localparam int MAXS  = 15;
    localparam int D     = 4;
    localparam int T     = 16;

    logic clock;
    logic reset;

    vend_dispense_scheduler_if #(.INV_W(INV_W)) bus ();

    vend_dispense_scheduler #(
        .INV_W(INV_W), .INIT_STOCK(INIT), .MAX_STOCK(MAXS),
        .DRIVE_CYCLES(D), .DROP_TIMEOUT(T)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: phase 0 idle, 1 serving m_slot (granted at edge m_t0), 2 jammed
    int         m_inv [3];
    logic [2:0] m_pend;
    int         m_ptr, m_phase, m_slot, m_t0, ecount;
    logic [2:0] e_motor, e_disp, e_ref;
    logic       e_fault;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: observed %0h, expected %0h", tag, ecount, obs, exp);
        end
    endtask

    function automatic bit drop_ready();
        return (m_phase == 1) && ((ecount + 1 - m_t0) > D);
    endfunction

    task automatic model_step(input logic r, input logic [2:0] vq, input logic dr, input logic rs,
                              input logic [1:0] rsl, input logic [3:0] rq, input logic fc);
        logic [2:0] acc;
        int dec, rel, v, s;
        bit found;
        ecount++;
        e_motor = '0; e_disp = '0; e_ref = '0;
        if (r) begin
            for (int i = 0; i < 3; i++) m_inv[i] = INIT;
            m_pend = '0; m_ptr = 2; m_phase = 0; m_slot = 0; m_t0 = 0; e_fault = 1'b0;
            return;
        end
        acc = '0;
        dec = -1;
        for (int i = 0; i < 3; i++) begin
            if (vq[i]) begin
                if (m_inv[i] == 0 || m_pend[i] || (m_phase == 1 && m_slot == i)) e_ref[i] = 1'b1;
                else acc[i] = 1'b1;
            end
        end
        if (m_phase == 0) begin
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                s = (m_ptr + k) % 3;
                if (!found && m_pend[s]) begin
                    found = 1'b1;
                    m_slot = s; m_pend[s] = 1'b0; m_ptr = s; m_t0 = ecount; m_phase = 1;
                    e_motor[s] = 1'b1;
                end
            end
        end else if (m_phase == 1) begin
            rel = ecount - m_t0;
            if (rel < D) e_motor[m_slot] = 1'b1;
            else if (rel > D) begin
                if (dr) begin
                    e_disp[m_slot] = 1'b1; dec = m_slot; m_phase = 0;
                end else if (rel == D + T) begin
                    e_ref[m_slot] = 1'b1; e_fault = 1'b1; m_phase = 2;
                end
            end
        end else if (fc) begin
            e_fault = 1'b0; m_phase = 0;
        end
        m_pend = m_pend | acc;
        for (int i = 0; i < 3; i++) begin
            v = m_inv[i] - ((dec == i) ? 1 : 0) + ((rs && int'(rsl) == i) ? int'(rq) : 0);
            m_inv[i] = (v > MAXS) ? MAXS : v;
        end
    endtask

    task automatic compare_all();
        logic [2:0] e_sold;
        for (int i = 0; i < 3; i++) e_sold[i] = (m_inv[i] == 0);
        check("motor_en",  32'(bus.motor_en),  32'(e_motor));
        check("busy",      32'(bus.busy),      32'(m_phase != 0));
        check("dispensed", 32'(bus.dispensed), 32'(e_disp));
        check("refund",    32'(bus.refund),    32'(e_ref));
        check("sold_out",  32'(bus.sold_out),  32'(e_sold));
        check("fault",     32'(bus.fault),     32'(e_fault));
        check("pending",   32'(dut.pending),   32'(m_pend));
        for (int i = 0; i < 3; i++)
            check($sformatf("inv%0d", i), 32'(dut.inv[i]), 32'(m_inv[i]));
    endtask

    task automatic tick(input logic r, input logic [2:0] vq, input logic dr, input logic rs,
                        input logic [1:0] rsl, input logic [3:0] rq, input logic fc);
        reset = r;
        bus.vend_req = vq; bus.drop_sense = dr; bus.restock = rs;
        bus.restock_slot = rsl; bus.restock_qty = rq; bus.fault_clear = fc;
        @(posedge clock);
        model_step(r, vq, dr, rs, rsl, rq, fc);
        #1;
        compare_all();
    endtask

    task automatic run(input int n, input bit autodrop);
        for (int k = 0; k < n; k++) tick(1'b0, 3'b000, autodrop && drop_ready(), 1'b0, 2'd0, 4'd0, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        tick(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    endtask

    initial begin
        int dprob;
        ecount = 0;
        do_reset();

        // single coke vend, drop sensed on cycle 7
        tick(1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        run(6, 1'b0);
        tick(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        check("first_vend_dispensed", 32'(bus.dispensed), 32'h1);
        check("first_vend_inv0", 32'(dut.inv[0]), 32'd7);
        check("first_vend_idle", 32'(bus.busy), 32'd0);

        // all three at once, then a late coke request while pepsi is being served
        do_reset();
        tick(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        run(8, 1'b1);
        for (int k = 0; k < 12 && m_slot != 1; k++) run(1, 1'b1);
        tick(1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        run(40, 1'b1);

        // drain pepsi, then one too many, then restock
        do_reset();
        for (int n = 0; n < 8; n++) begin
            tick(1'b0, 3'b010, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
            run(12, 1'b1);
        end
        check("pepsi_sold_out", 32'(bus.sold_out), 32'h2);
        tick(1'b0, 3'b010, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        check("pepsi_refund", 32'(bus.refund), 32'h2);
        run(3, 1'b0);
        tick(1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 4'd3, 1'b0);
        check("pepsi_restocked", 32'(dut.inv[1]), 32'd3);

        // jam timeout with soft_drink pending, then operator clear
        do_reset();
        tick(1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        tick(1'b0, 3'b100, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        run(30, 1'b0);
        check("jam_fault", 32'(bus.fault), 32'd1);
        check("jam_pending", 32'(dut.pending), 32'h4);
        tick(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
        run(15, 1'b1);

        // restock saturation, then drop and restock colliding on one slot
        do_reset();
        tick(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 4'd15, 1'b0);
        check("restock_sat", 32'(dut.inv[0]), 32'd15);
        do_reset();
        for (int n = 0; n < 3; n++) begin
            tick(1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
            run(12, 1'b1);
        end
        tick(1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        for (int k = 0; k < 20 && !drop_ready(); k++) run(1, 1'b0);
        tick(1'b0, 3'b000, 1'b1, 1'b1, 2'd0, 4'd2, 1'b0);
        check("drop_plus_restock", 32'(dut.inv[0]), 32'd6);

        // reset in the middle of a drive phase
        tick(1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        run(3, 1'b0);
        tick(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        check("reset_motor_off", 32'(bus.motor_en), 32'd0);
        check("reset_inv0", 32'(dut.inv[0]), 32'(INIT));
        run(2, 1'b0);

        // randomized traffic in blocks with varying drop likelihood
        for (int b = 0; b < 12; b++) begin
            dprob = (b % 3 == 2) ? 0 : 3;
            for (int k = 0; k < 200; k++) begin
                logic [2:0] vq;
                logic dr;
                vq = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
                dr = (drop_ready() && dprob != 0 && $urandom_range(0, dprob) == 0)
                     || ($urandom_range(0, 15) == 0);
                tick(($urandom_range(0, 499) == 0), vq, dr,
                     ($urandom_range(0, 19) == 0), 2'($urandom), 4'($urandom),
                     ($urandom_range(0, 7) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
